// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state type, Funct3 codes and op legality helpers for the load/store unit.
package lsu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    function automatic logic op_ok(input logic st, input logic [2:0] f, input logic [1:0] a);
        return st ? (f == SB || (f == SH && !a[0]) || (f == SW && a == 2'd0))
                  : (f == LB || f == LBU || ((f == LH || f == LHU) && !a[0]) || (f == LW && a == 2'd0));
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f, input logic [1:0] a);
        return f == SB ? 4'b0001 << a : f == SH ? 4'b0011 << a : 4'b1111;
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic [WORD-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [WORD-1:0] data
);
    logic [15:0] half;
    logic [7:0]  byte_lane;

    always_comb begin
        half      = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_lane = offset[0] ? half[15:8] : half[7:0];
        data = funct3 == LB  ? {{(WORD-8){byte_lane[7]}}, byte_lane}
             : funct3 == LBU ? {{(WORD-8){1'b0}}, byte_lane}
             : funct3 == LH  ? {{(WORD-16){half[15]}}, half}
             : funct3 == LHU ? {{(WORD-16){1'b0}}, half}
             : rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding memory op FSM (IDLE/REQ/RESP) with alignment checks,
// store lane replication and load lane extraction.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Req_valid,
    output logic            Req_ready,
    input  logic            Is_store,
    input  logic [2:0]      Funct3,
    input  logic [WORD-1:0] Addr_in,
    input  logic [WORD-1:0] Store_data_in,
    input  logic [RD_W-1:0] Rd_in,
    output logic            Mem_req,
    output logic            Mem_we,
    output logic [WORD-1:0] Mem_addr,
    output logic [WORD-1:0] Mem_wdata,
    output logic [3:0]      Mem_be,
    input  logic            Mem_ack,
    input  logic [WORD-1:0] Mem_rdata,
    output logic            Resp_valid,
    output logic [WORD-1:0] Resp_data,
    output logic [RD_W-1:0] Resp_rd,
    output logic            Misaligned
);
    state_t          state;
    logic            st;
    logic [2:0]      f3;
    logic [1:0]      off;
    logic [RD_W-1:0] rd;
    logic [WORD-1:0] load_data;
    logic [WORD-1:0] wdata;

    assign Req_ready = state == IDLE;
    assign wdata = Funct3 == SB ? {(WORD/8){Store_data_in[7:0]}}
                 : Funct3 == SH ? {(WORD/16){Store_data_in[15:0]}}
                 : Store_data_in;

    lsu_load_align #(.WORD(WORD)) u_align (
        .rdata (Mem_rdata),
        .funct3(f3),
        .offset(off),
        .data  (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            st         <= 1'b0;
            f3         <= 3'd0;
            off        <= 2'd0;
            rd         <= '0;
            Mem_req    <= 1'b0;
            Mem_we     <= 1'b0;
            Mem_addr   <= '0;
            Mem_wdata  <= '0;
            Mem_be     <= 4'd0;
            Resp_valid <= 1'b0;
            Resp_data  <= '0;
            Resp_rd    <= '0;
            Misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Req_valid) begin
                    st  <= Is_store;
                    f3  <= Funct3;
                    off <= Addr_in[1:0];
                    rd  <= Rd_in;
                    if (op_ok(Is_store, Funct3, Addr_in[1:0])) begin
                        state     <= REQ;
                        Mem_req   <= 1'b1;
                        Mem_we    <= Is_store;
                        Mem_addr  <= {Addr_in[WORD-1:2], 2'b00};
                        Mem_wdata <= Is_store ? wdata : '0;
                        Mem_be    <= Is_store ? store_be(Funct3, Addr_in[1:0]) : 4'b1111;
                    end else begin
                        // faulting ops skip memory and report straight away
                        state      <= RESP;
                        Resp_valid <= 1'b1;
                        Misaligned <= 1'b1;
                        Resp_data  <= '0;
                        Resp_rd    <= Is_store ? '0 : Rd_in;
                    end
                end
                REQ: if (Mem_ack) begin
                    state      <= RESP;
                    Mem_req    <= 1'b0;
                    Mem_we     <= 1'b0;
                    Resp_valid <= 1'b1;
                    Resp_data  <= st ? '0 : load_data;
                    Resp_rd    <= st ? '0 : rd;
                end
                RESP: begin
                    state      <= IDLE;
                    Resp_valid <= 1'b0;
                    Misaligned <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus hand sequences for delayed ack and mid-transaction reset.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        Req_valid, Req_ready, Is_store;
    logic [2:0]  Funct3;
    logic [31:0] Addr_in, Store_data_in;
    logic [4:0]  Rd_in;
    logic        Mem_req, Mem_we, Mem_ack;
    logic [31:0] Mem_addr, Mem_wdata, Mem_rdata;
    logic [3:0]  Mem_be;
    logic        Resp_valid, Misaligned;
    logic [31:0] Resp_data;
    logic [4:0]  Resp_rd;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst), .Req_valid(Req_valid), .Req_ready(Req_ready), .Is_store(Is_store),
        .Funct3(Funct3), .Addr_in(Addr_in), .Store_data_in(Store_data_in), .Rd_in(Rd_in),
        .Mem_req(Mem_req), .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
        .Mem_be(Mem_be), .Mem_ack(Mem_ack), .Mem_rdata(Mem_rdata), .Resp_valid(Resp_valid),
        .Resp_data(Resp_data), .Resp_rd(Resp_rd), .Misaligned(Misaligned)
    );

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        mis;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
        logic [4:0]  erd;
    } vec_t;

    vec_t v[15];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
        else pass_cnt++;
    endtask

    task automatic drive(input logic s, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r);
        Req_valid = 1'b1; Is_store = s; Funct3 = f; Addr_in = a; Store_data_in = d; Rd_in = r;
    endtask

    initial begin
        v[0]  = '{1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 1'b0, 32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 5'd5};
        v[1]  = '{1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF1234, 5'd7, 1'b0, 32'h100, 4'hF, 32'h0, 32'hFFFFFF80, 5'd7};
        v[2]  = '{1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF1234, 5'd8, 1'b0, 32'h100, 4'hF, 32'h0, 32'h00000080, 5'd8};
        v[3]  = '{1'b0, 3'd1, 32'h102, 32'h0, 32'h80FF1234, 5'd9, 1'b0, 32'h100, 4'hF, 32'h0, 32'hFFFF80FF, 5'd9};
        v[4]  = '{1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF1234, 5'd10, 1'b0, 32'h100, 4'hF, 32'h0, 32'h000080FF, 5'd10};
        v[5]  = '{1'b0, 3'd0, 32'h101, 32'h0, 32'h80FF1234, 5'd11, 1'b0, 32'h100, 4'hF, 32'h0, 32'h00000012, 5'd11};
        v[6]  = '{1'b0, 3'd1, 32'h100, 32'h0, 32'h00008001, 5'd12, 1'b0, 32'h100, 4'hF, 32'h0, 32'hFFFF8001, 5'd12};
        v[7]  = '{1'b1, 3'd0, 32'h301, 32'h1234ABCD, 32'hFFFFFFFF, 5'd9, 1'b0, 32'h300, 4'h2, 32'hCDCDCDCD, 32'h0, 5'd0};
        v[8]  = '{1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 5'd9, 1'b0, 32'h200, 4'hC, 32'hABCDABCD, 32'h0, 5'd0};
        v[9]  = '{1'b1, 3'd2, 32'h404, 32'hCAFEF00D, 32'hFFFFFFFF, 5'd9, 1'b0, 32'h404, 4'hF, 32'hCAFEF00D, 32'h0, 5'd0};
        v[10] = '{1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0};
        v[11] = '{1'b0, 3'd1, 32'h103, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0};
        v[12] = '{1'b1, 3'd2, 32'h402, 32'h5, 32'h0, 5'd3, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0};
        v[13] = '{1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 5'd3, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0};
        v[14] = '{1'b1, 3'd4, 32'h100, 32'h5, 32'h0, 5'd3, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, 5'd0};

        rst = 1'b1; Req_valid = 1'b0; Is_store = 1'b0; Funct3 = 3'd0; Addr_in = '0;
        Store_data_in = '0; Rd_in = '0; Mem_ack = 1'b0; Mem_rdata = '0;
        #2;
        chk("rst Req_ready", 32'(Req_ready), 32'd1);
        chk("rst Mem_req", 32'(Mem_req), 32'd0);
        chk("rst Resp_valid", 32'(Resp_valid), 32'd0);
        chk("rst Misaligned", 32'(Misaligned), 32'd0);
        chk("rst Mem_addr", Mem_addr, 32'd0);
        chk("rst Mem_be", 32'(Mem_be), 32'd0);
        chk("rst Resp_data", Resp_data, 32'd0);
        chk("rst Resp_rd", 32'(Resp_rd), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            drive(v[i].st, v[i].f3, v[i].addr, v[i].sd, v[i].rd);
            @(posedge clk); #1;
            Req_valid = 1'b0;
            chk($sformatf("v%0d Req_ready busy", i), 32'(Req_ready), 32'd0);
            if (v[i].mis) begin
                chk($sformatf("v%0d mis Mem_req", i), 32'(Mem_req), 32'd0);
                chk($sformatf("v%0d mis Resp_valid", i), 32'(Resp_valid), 32'd1);
                chk($sformatf("v%0d mis Misaligned", i), 32'(Misaligned), 32'd1);
                chk($sformatf("v%0d mis Resp_data", i), Resp_data, 32'd0);
            end else begin
                chk($sformatf("v%0d Mem_req", i), 32'(Mem_req), 32'd1);
                chk($sformatf("v%0d Mem_addr", i), Mem_addr, v[i].maddr);
                chk($sformatf("v%0d Mem_be", i), 32'(Mem_be), 32'(v[i].be));
                chk($sformatf("v%0d Mem_we", i), 32'(Mem_we), 32'(v[i].st));
                if (v[i].st) chk($sformatf("v%0d Mem_wdata", i), Mem_wdata, v[i].wdata);
                chk($sformatf("v%0d early Resp_valid", i), 32'(Resp_valid), 32'd0);
                Mem_ack = 1'b1; Mem_rdata = v[i].rdata;
                @(posedge clk); #1;
                Mem_ack = 1'b0;
                chk($sformatf("v%0d Resp_valid", i), 32'(Resp_valid), 32'd1);
                chk($sformatf("v%0d Resp_data", i), Resp_data, v[i].data);
                chk($sformatf("v%0d Resp_rd", i), 32'(Resp_rd), 32'(v[i].erd));
                chk($sformatf("v%0d Misaligned", i), 32'(Misaligned), 32'd0);
                chk($sformatf("v%0d Mem_req done", i), 32'(Mem_req), 32'd0);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d Resp_valid drop", i), 32'(Resp_valid), 32'd0);
            chk($sformatf("v%0d Misaligned drop", i), 32'(Misaligned), 32'd0);
            chk($sformatf("v%0d Req_ready back", i), 32'(Req_ready), 32'd1);
        end

        // delayed ack with a competing request held by upstream
        drive(1'b0, 3'd2, 32'h500, 32'h0, 5'd4);
        @(posedge clk); #1;
        drive(1'b1, 3'd2, 32'h600, 32'h11111111, 5'd6);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("dly%0d Mem_req", c), 32'(Mem_req), 32'd1);
            chk($sformatf("dly%0d Mem_addr", c), Mem_addr, 32'h500);
            chk($sformatf("dly%0d Mem_we", c), 32'(Mem_we), 32'd0);
            chk($sformatf("dly%0d Mem_be", c), 32'(Mem_be), 32'hF);
            chk($sformatf("dly%0d Req_ready", c), 32'(Req_ready), 32'd0);
            chk($sformatf("dly%0d Resp_valid", c), 32'(Resp_valid), 32'd0);
            @(posedge clk); #1;
        end
        Mem_ack = 1'b1; Mem_rdata = 32'h0BADF00D;
        @(posedge clk); #1;
        Mem_ack = 1'b0; Req_valid = 1'b0;
        chk("dly Resp_valid", 32'(Resp_valid), 32'd1);
        chk("dly Resp_data", Resp_data, 32'h0BADF00D);
        chk("dly Resp_rd", 32'(Resp_rd), 32'd4);
        @(posedge clk); #1;
        chk("dly idle Req_ready", 32'(Req_ready), 32'd1);
        chk("dly second not taken", 32'(Mem_req), 32'd0);

        // stray ack in IDLE is ignored
        Mem_ack = 1'b1;
        @(posedge clk); #1;
        Mem_ack = 1'b0;
        chk("stray ack Resp_valid", 32'(Resp_valid), 32'd0);
        chk("stray ack Req_ready", 32'(Req_ready), 32'd1);

        // reset while waiting in REQ
        drive(1'b0, 3'd2, 32'h700, 32'h0, 5'd2);
        @(posedge clk); #1;
        Req_valid = 1'b0;
        chk("rstreq Mem_req before", 32'(Mem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstreq Mem_req async", 32'(Mem_req), 32'd0);
        chk("rstreq Req_ready", 32'(Req_ready), 32'd1);
        chk("rstreq Mem_addr", Mem_addr, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        Mem_ack = 1'b1; Mem_rdata = 32'h12345678;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("rstreq%0d Resp_valid", c), 32'(Resp_valid), 32'd0);
            chk($sformatf("rstreq%0d Mem_req", c), 32'(Mem_req), 32'd0);
        end
        Mem_ack = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
